// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported synchronous data memory.
//
// Port A (core) and port B (loader/debug) each present req/we/addr/wdata and hold them
// until granted. Grants are combinational from the requests and the registered arbiter
// state. Contention is resolved round-robin, except that port B may lock the memory for a
// burst, limited to MAX_BURST grants while A is waiting. Read data returns one cycle after
// the grant on the winning port's rvalid/rdata. rdata holds its last valid value.
//
// Ports:
//   clk, resetn                         clock, synchronous active-low reset
//   a_req, a_we, a_addr, a_wdata        core request
//   a_gnt, a_rvalid, a_rdata            core grant and read return
//   b_req, b_we, b_addr, b_wdata, b_lock  loader request, with burst lock
//   b_gnt, b_rvalid, b_rdata            loader grant and read return
//   mem_en, mem_we, mem_addr, mem_wdata memory access
//   mem_rdata                           memory read data, one cycle after a read access

module dmem_arbiter #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic              b_lock,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   // State records which port (if any) was granted in the previous cycle.
   typedef enum logic [1:0] {StIdle, StServeA, StServeB, StLockB} state_e;

   state_e              state_q, state_d;
   logic                last_b_q, last_b_d;  // 1: B was served most recently
   logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic                a_pend_q, b_pend_q;  // read granted last cycle, data due now
   logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
   logic                burst_full;

   assign burst_full = (burst_cnt_q == CNT_W'(MAX_BURST));

   // State register and read-return registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= StIdle;
         last_b_q    <= 1'b1;
         burst_cnt_q <= '0;
         a_pend_q    <= 1'b0;
         b_pend_q    <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_b_q    <= last_b_d;
         burst_cnt_q <= burst_cnt_d;
         a_pend_q    <= a_gnt & ~a_we;
         b_pend_q    <= b_gnt & ~b_we;
         if (a_rvalid) a_rdata_q <= mem_rdata;
         if (b_rvalid) b_rdata_q <= mem_rdata;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d     = StIdle;
      last_b_d    = last_b_q;
      burst_cnt_d = burst_cnt_q;
      if (a_gnt) begin
         state_d  = StServeA;
         last_b_d = 1'b0;
      end else if (b_gnt) begin
         state_d  = b_lock ? StLockB : StServeB;
         last_b_d = 1'b1;
      end
      // The burst counter only measures how long A has been held off by a lock.
      if (a_gnt || !b_lock || !b_req) begin
         burst_cnt_d = '0;
      end else if (b_gnt && a_req && !burst_full) begin
         burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end
   end

   // Output logic: grants and the memory-side mux.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (resetn) begin
         if (state_q == StLockB && b_req && b_lock) begin
            if (a_req && burst_full) a_gnt = 1'b1;
            else                     b_gnt = 1'b1;
         end else if (a_req && b_req) begin
            a_gnt = last_b_q;
            b_gnt = ~last_b_q;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end

      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (a_gnt) begin
         mem_we    = a_we;
         mem_addr  = a_addr;
         mem_wdata = a_wdata;
      end else if (b_gnt) begin
         mem_we    = b_we;
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
      end
   end

   assign mem_en = a_gnt | b_gnt;

   // Gating with resetn drops a read whose return would land in a reset cycle.
   assign a_rvalid = a_pend_q & resetn;
   assign b_rvalid = b_pend_q & resetn;
   assign a_rdata  = a_rvalid ? mem_rdata : a_rdata_q;
   assign b_rdata  = b_rvalid ? mem_rdata : b_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5: word-address width of the shared data memory (32 words).
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter MAX_BURST, default 8: maximum number of consecutive locked port-B grants while port A is waiting.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 a_req  input  1  core port request; a_we, a_addr and a_wdata are held stable until granted.
REQ-007 a_we  input  1  core port write enable (1 = write, 0 = read).
REQ-008 a_addr  input  ADDR_W  core port word address.
REQ-009 a_wdata  input  DATA_W  core port write data.
REQ-010 a_gnt  output  1  core request accepted this cycle.
REQ-011 a_rvalid  output  1  core read data valid.
REQ-012 a_rdata  output  DATA_W  core read data.
REQ-013 b_req, b_we, b_addr, b_wdata  input  1/1/ADDR_W/DATA_W  loader/debug port; same meaning as the port-A signals.
REQ-014 b_lock  input  1  loader requests back-to-back ownership (burst).
REQ-015 b_gnt, b_rvalid, b_rdata  output  1/1/DATA_W  loader port grant, read valid and read data.
REQ-016 mem_en, mem_we  output  1/1  memory access strobe and write enable.
REQ-017 mem_addr, mem_wdata  output  ADDR_W/DATA_W  memory address and write data.
REQ-018 mem_rdata  input  DATA_W  synchronous memory read data, valid one cycle after a mem_en=1, mem_we=0 access.

Function
REQ-019 Grant outputs shall be combinational from the request inputs and the registered arbiter state; at most one of a_gnt and b_gnt shall be 1 in any cycle.
REQ-020 A port with req=0 shall never be granted; a sole requester shall be granted in the same cycle.
REQ-021 When both ports request without an active lock, the port other than last_served shall be granted (round-robin).
REQ-022 last_served shall update on every grant to the port granted in that cycle.
REQ-023 mem_en = a_gnt | b_gnt; mem_we, mem_addr and mem_wdata shall be driven from the granted port's signals.
REQ-024 When no port is granted, mem_we, mem_addr and mem_wdata shall be 0.
REQ-025 For a granted read, the winning port's rvalid shall be 1 exactly one cycle later, with rdata = mem_rdata; the other port's rvalid shall be 0 in that cycle.
REQ-026 rdata of a port shall hold its last valid value until that port's next rvalid.
REQ-027 Writes shall produce no rvalid pulse.
REQ-028 The controller shall use an FSM with states IDLE, SERVE_A, SERVE_B and LOCK_B, recording the grant of the previous cycle.
REQ-029 Any cycle with no grant shall lead to IDLE.
REQ-030 A grant to A shall lead to SERVE_A.
REQ-031 A grant to B with b_lock=0 shall lead to SERVE_B.
REQ-032 A grant to B with b_lock=1 shall lead to LOCK_B.
REQ-033 In LOCK_B with b_req=1 and b_lock=1, B shall win over A regardless of round-robin while burst_cnt < MAX_BURST.
REQ-034 burst_cnt shall increment on each locked B grant made while a_req=1, saturating at MAX_BURST.
REQ-035 When burst_cnt = MAX_BURST and a_req=1, A shall be granted, burst_cnt shall clear, and the FSM shall go to SERVE_A.
REQ-036 burst_cnt shall clear whenever b_lock=0, b_req=0 or A is granted.
REQ-037 Locked B grants made while a_req=0 shall not increment burst_cnt.

Reset
REQ-038 While resetn=0 in a cycle, a_gnt, b_gnt and mem_en shall be forced to 0.
REQ-039 On reset, the FSM shall enter IDLE, last_served = B (so A wins the first contention), burst_cnt = 0, a_rvalid = b_rvalid = 0, and a_rdata = b_rdata = 0.
REQ-040 A read granted in the cycle before reset is asserted shall not produce rvalid after reset.

Verification
REQ-041 Reset, then a_req=1, a_we=1, a_addr=3, a_wdata=0xDEADBEEF -> a_gnt=1 and mem_en=1, mem_we=1, mem_addr=3 in the same cycle; no a_rvalid.
REQ-042 Read of addr 3 via B after REQ-041 -> b_gnt=1, then one cycle later b_rvalid=1, b_rdata=0xDEADBEEF and a_rvalid=0.
REQ-043 Both ports request reads continuously from reset with b_lock=0 -> grants alternate A,B,A,B; each rvalid appears one cycle after its grant.
REQ-044 b_lock=1 and b_req=1 held with a_req=1, MAX_BURST=8 -> 8 consecutive b_gnt, then a_gnt on the 9th cycle, then B regains the grant.
REQ-045 Assert resetn=0 on the cycle after an A read grant -> a_rvalid stays 0, and both grants are 0 throughout reset.
REQ-046 No requests for 5 cycles -> mem_en=0, mem_addr=0, FSM in IDLE, and both rvalid signals 0.
